cpu_datapath_regs: RTL and testbench

- Register stage directly upstream of the B-bus select mux. Owns PC, IR, MDR, R and MAR.
- Loads these registers from the C bus, which carries the ALU result, under control-unit enables.
- Runs the external memory read/write handshake that fills MDR and drains it.
- Drives PC, IR, MDR and R straight into the B-bus mux; the 2-bit select M stays in the control unit.

---
 rtl/cpu_datapath_regs_pkg.sv | 21 ++
 rtl/cpu_datapath_regs_mem_handshake_fsm.sv | 114 +++++++++++
 rtl/cpu_datapath_regs.sv | 84 ++++++++
 tb/tb_cpu_datapath_regs.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_datapath_regs_pkg.sv
// Shared definitions for the B-bus register stage: FSM encodings, default widths
// and the B-bus select codes the control unit uses with this block's outputs.
package cpu_datapath_regs_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    BSEL_PC  = 2'b00,
    BSEL_IR  = 2'b01,
    BSEL_MDR = 2'b10,
    BSEL_R   = 2'b11
  } bsel_e;

endpackage

// File: rtl/cpu_datapath_regs_mem_handshake_fsm.sv
// External memory request/acknowledge sequencer with timeout abort.
// Latches address/write data at start and reports done/err as one-cycle pulses.
module mem_handshake_fsm
  import cpu_datapath_regs_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              idle,
  output logic              rd_capture
);

  // Abort fires in the cycle whose count would reach TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e        state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              req_nxt, we_nxt, done_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    req_nxt    = mem_req;
    we_nxt     = mem_we;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    rd_capture = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Read wins a simultaneous read/write start; the write is dropped.
        if (start_rd) begin
          state_nxt = ST_RD_WAIT;
          addr_nxt  = mar;
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else if (start_wr) begin
          state_nxt = ST_WR_WAIT;
          addr_nxt  = mar;
          wdata_nxt = mdr;
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ack) begin
          rd_capture = (state == ST_RD_WAIT);
          state_nxt  = ST_IDLE;
          req_nxt    = 1'b0;
          we_nxt     = 1'b0;
          done_nxt   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
      end
    endcase
  end

  assign idle = (state == ST_IDLE);
  assign busy = ~idle;

endmodule

// File: rtl/cpu_datapath_regs.sv
// PC/IR/MDR/R/MAR register stage feeding the B-bus mux, loaded from the C bus,
// with MDR filled and drained through the external memory handshake.
module cpu_datapath_regs
  import cpu_datapath_regs_pkg::*;
#(
  parameter int              DATA_W  = DATA_W_DEF,
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] PC_RST = '0,
  parameter int              TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] C_bus,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              ld_ir,
  input  logic              ld_r,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] R,
  output logic [ADDR_W-1:0] MAR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic idle, rd_capture, bus_ld_ok;

  mem_handshake_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .start_rd  (mem_rd),
    .start_wr  (mem_wr),
    .mar       (MAR),
    .mdr       (MDR),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .idle      (idle),
    .rd_capture(rd_capture)
  );

  // MAR/MDR must not move under an in-flight or just-starting transaction.
  assign bus_ld_ok = idle & ~mem_rd & ~mem_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC  <= PC_RST;
      IR  <= '0;
      R   <= '0;
      MAR <= '0;
      MDR <= '0;
    end else begin
      if (ld_pc)       PC <= C_bus;
      else if (inc_pc) PC <= PC + DATA_W'(1);
      if (ld_ir) IR <= MDR;
      if (ld_r)  R  <= C_bus;
      if (bus_ld_ok && ld_mar) MAR <= C_bus[ADDR_W-1:0];
      if (rd_capture)                MDR <= mem_rdata;
      else if (bus_ld_ok && ld_mdr)  MDR <= C_bus;
    end
  end

endmodule

// File: tb/tb_cpu_datapath_regs.sv
// Directed bench for cpu_datapath_regs: register-load vector table plus
// hand-written memory handshake sequences.
module tb_cpu_datapath_regs;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] C_bus;
  logic       ld_pc, inc_pc, ld_ir, ld_r, ld_mar, ld_mdr, mem_rd, mem_wr;
  logic [7:0] PC, IR, MDR, R, MAR, mem_addr, mem_wdata, mem_rdata;
  logic       mem_req, mem_we, mem_ack, busy, done, err;

  int n_pass = 0;
  int n_total = 0;

  cpu_datapath_regs dut (
    .clk(clk), .reset(reset), .C_bus(C_bus),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_ir(ld_ir), .ld_r(ld_r),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .PC(PC), .IR(IR), .MDR(MDR), .R(R), .MAR(MAR),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld_pc, inc_pc, ld_ir, ld_r, ld_mar, ld_mdr;
    logic [7:0] c;
    logic [7:0] e_pc, e_ir, e_r, e_mar, e_mdr;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mkv(input logic lp, ip, li, lr, lma, lmd,
                               input logic [7:0] c, epc, eir, er, emar, emdr);
    vec_t v;
    v.ld_pc = lp; v.inc_pc = ip; v.ld_ir = li; v.ld_r = lr; v.ld_mar = lma; v.ld_mdr = lmd;
    v.c = c; v.e_pc = epc; v.e_ir = eir; v.e_r = er; v.e_mar = emar; v.e_mdr = emdr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_pc = 0; inc_pc = 0; ld_ir = 0; ld_r = 0; ld_mar = 0; ld_mdr = 0;
    mem_rd = 0; mem_wr = 0; mem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; C_bus = 8'h55; mem_rdata = 8'h00;
    idle_inputs();
    ld_pc = 1;

    // Reset overrides a held ld_pc.
    step();
    chk("rst_pc", PC, 8'h00);
    chk("rst_regs", {IR, MDR, R, MAR}, 32'h0);
    chk("rst_mem", {mem_addr, mem_wdata, 7'b0, mem_req, mem_we, busy, done, err}, 32'h0);
    reset = 0;
    step();
    chk("post_rst_ldpc", PC, 8'h55);
    ld_pc = 0;

    vt[0] = mkv(1,0,0,0,0,0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[1] = mkv(0,1,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[2] = mkv(1,1,0,0,0,0, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[3] = mkv(0,1,0,0,0,0, 8'h77, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[4] = mkv(0,0,0,1,0,0, 8'h9C, 8'h11, 8'h00, 8'h9C, 8'h00, 8'h00);
    vt[5] = mkv(0,0,0,0,1,0, 8'h3C, 8'h11, 8'h00, 8'h9C, 8'h3C, 8'h00);
    vt[6] = mkv(0,0,0,0,0,1, 8'h5A, 8'h11, 8'h00, 8'h9C, 8'h3C, 8'h5A);
    vt[7] = mkv(0,0,1,0,0,0, 8'h00, 8'h11, 8'h5A, 8'h9C, 8'h3C, 8'h5A);
    vt[8] = mkv(0,0,1,0,0,1, 8'h66, 8'h11, 8'h5A, 8'h9C, 8'h3C, 8'h66);
    vt[9] = mkv(0,0,0,0,1,0, 8'h80, 8'h11, 8'h5A, 8'h9C, 8'h80, 8'h66);

    for (int i = 0; i < 10; i++) begin
      ld_pc = vt[i].ld_pc; inc_pc = vt[i].inc_pc; ld_ir = vt[i].ld_ir;
      ld_r = vt[i].ld_r; ld_mar = vt[i].ld_mar; ld_mdr = vt[i].ld_mdr; C_bus = vt[i].c;
      step();
      chk($sformatf("vec%0d_pc", i), PC, vt[i].e_pc);
      chk($sformatf("vec%0d_ir", i), IR, vt[i].e_ir);
      chk($sformatf("vec%0d_r", i), R, vt[i].e_r);
      chk($sformatf("vec%0d_mar", i), MAR, vt[i].e_mar);
      chk($sformatf("vec%0d_mdr", i), MDR, vt[i].e_mdr);
    end
    idle_inputs();

    // Read with ack two cycles after req.
    ld_mar = 1; C_bus = 8'h3C; step(); ld_mar = 0;
    mem_rd = 1; step(); mem_rd = 0;
    chk("rd_req", {mem_req, mem_we, busy}, 3'b101);
    chk("rd_addr", mem_addr, 8'h3C);
    step();
    chk("rd_wait", {mem_req, busy, done}, 3'b110);
    mem_ack = 1; mem_rdata = 8'hA7; step(); mem_ack = 0;
    chk("rd_done", {mem_req, busy, done, err}, 4'b0010);
    chk("rd_mdr", MDR, 8'hA7);
    ld_ir = 1; step(); ld_ir = 0;
    chk("rd_ir", IR, 8'hA7);
    chk("rd_done_pulse", done, 1'b0);

    // Simultaneous rd/wr -> read only; then back-to-back write.
    ld_mdr = 1; ld_mar = 1; C_bus = 8'h80; step();
    ld_mdr = 1; ld_mar = 0; C_bus = 8'h5A; step(); ld_mdr = 0;
    chk("setup_mdr_mar", {MDR, MAR}, 16'h5A80);
    mem_rd = 1; mem_wr = 1; step(); mem_rd = 0; mem_wr = 0;
    chk("rdwr_is_read", {mem_req, mem_we}, 2'b10);
    chk("rdwr_addr", mem_addr, 8'h80);
    mem_ack = 1; mem_rdata = 8'h5A; step(); mem_ack = 0;
    chk("rdwr_done", done, 1'b1);
    mem_wr = 1; step(); mem_wr = 0;
    chk("wr_start_on_done", {mem_req, mem_we, busy}, 3'b111);
    chk("wr_wdata", mem_wdata, 8'h5A);
    ld_mdr = 1; ld_mar = 1; C_bus = 8'hEE; mem_rd = 1; step();
    ld_mdr = 0; ld_mar = 0; mem_rd = 0;
    chk("wr_ldmdr_ignored", {MDR, MAR}, 16'h5A80);
    chk("wr_rd_ignored", {mem_req, mem_we}, 2'b11);
    mem_ack = 1; step(); mem_ack = 0;
    chk("wr_done", {mem_req, busy, done, err}, 4'b0010);
    chk("wr_mdr_kept", MDR, 8'h5A);

    // Timeout: err exactly TIMEOUT cycles after req rises.
    mem_rd = 1; step(); mem_rd = 0;
    chk("to_req", mem_req, 1'b1);
    for (int k = 1; k < 15; k++) begin
      step();
      chk($sformatf("to_wait%0d", k), {mem_req, err, done}, 3'b100);
    end
    step();
    chk("to_err", {mem_req, busy, done, err}, 4'b0001);
    chk("to_mdr", MDR, 8'h5A);
    step();
    chk("to_err_pulse", err, 1'b0);

    // Ack on the final cycle wins over timeout.
    mem_rd = 1; step(); mem_rd = 0;
    for (int k = 1; k < 15; k++) step();
    chk("late_still_wait", {mem_req, err}, 2'b10);
    mem_ack = 1; mem_rdata = 8'h3D; step(); mem_ack = 0;
    chk("late_ack_done", {mem_req, done, err}, 3'b010);
    chk("late_ack_mdr", MDR, 8'h3D);

    // Reset mid-RD_WAIT drops the transaction.
    mem_rd = 1; step(); mem_rd = 0;
    step();
    reset = 1; step(); reset = 0;
    chk("midrst_state", {mem_req, busy, done, err}, 4'b0000);
    chk("midrst_mdr", MDR, 8'h00);
    mem_ack = 1; mem_rdata = 8'hC3; step(); mem_ack = 0;
    chk("midrst_ack_ignored", {mem_req, busy, done}, 3'b000);
    chk("midrst_ack_mdr", MDR, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
